// File: rtl/mod3_serial_encoder.sv
// rtl/mod3_serial_encoder.sv - Serializes a payload word MSB-first and appends 2 check bits
// The appended bits make the whole codeword a multiple of 3.
module mod3_serial_encoder #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, CHK1, CHK0} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        res, res_n;
  logic              ser_out_n, ser_valid_n, ser_first_n, ser_last_n;
  logic              accept;

  // Residue after shifting in one more bit: (2*r + b) mod 3.
  function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
    case (r)
      2'd0:    res_step = {1'b0, b};
      2'd1:    res_step = b ? 2'd0 : 2'd2;
      default: res_step = b ? 2'd2 : 2'd1;
    endcase
  endfunction

  assign in_ready = !rst && (state == IDLE || state == CHK0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    res_n       = res;
    ser_out_n   = 1'b0;
    ser_valid_n = 1'b0;
    ser_first_n = 1'b0;
    ser_last_n  = 1'b0;
    case (state)
      IDLE, CHK0: begin
        if (accept) begin
          state_n     = DATA;
          ser_out_n   = in_data[DATA_W-1];
          ser_valid_n = 1'b1;
          ser_first_n = 1'b1;
          shreg_n     = in_data << 1;
          res_n       = res_step(2'd0, in_data[DATA_W-1]);
          cnt_n       = CNT_W'(1);
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        ser_valid_n = 1'b1;
        if (cnt == CNT_W'(DATA_W)) begin
          // c[1] is set only when the final residue is 1
          state_n   = CHK1;
          ser_out_n = (res == 2'd1);
        end else begin
          ser_out_n = shreg[DATA_W-1];
          shreg_n   = shreg << 1;
          res_n     = res_step(res, shreg[DATA_W-1]);
          cnt_n     = cnt + 1'b1;
        end
      end
      CHK1: begin
        state_n     = CHK0;
        ser_valid_n = 1'b1;
        ser_last_n  = 1'b1;
        ser_out_n   = (res == 2'd2);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      res       <= 2'd0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      res       <= res_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      ser_first <= ser_first_n;
      ser_last  <= ser_last_n;
      busy      <= ser_valid_n;
    end
  end

endmodule

// File: tb/tb_mod3_serial_encoder.sv
// tb/tb_mod3_serial_encoder.sv - Scoreboard bench for mod3_serial_encoder
// Expected codewords come from plain arithmetic on each accepted word.
module tb_mod3_serial_encoder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready, ser_out, ser_valid, ser_first, ser_last, busy;

  int tests = 0;
  int fails = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] cw;
  logic [W+1:0] last_cw;
  int           nbits    = 0;
  int           run      = 0;
  int           last_run = 0;

  mod3_serial_encoder #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] d);
    int m;
    int c;
    m = int'(d) % 3;
    c = (3 - m) % 3;
    return (W+2)'(int'(d) * 4 + c);
  endfunction

  // Monitor: reassembles codewords and checks framing against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      run   = 0;
    end else begin
      check("busy_eq_valid", busy, ser_valid);
      check("in_ready", in_ready, !ser_valid || ser_last);
      if (ser_valid) begin
        run++;
        check("ser_first", ser_first, nbits == 0);
        check("ser_last", ser_last, nbits == W + 1);
        cw = (nbits == 0) ? (W+2)'(ser_out) : {cw[W:0], ser_out};
        nbits++;
        if (nbits == W + 2) begin
          nbits   = 0;
          last_cw = cw;
          check("cw_mod3", 32'(int'(cw) % 3), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            check("codeword", 32'(cw), 32'(exp_q.pop_front()));
          end
        end
      end else begin
        if (nbits != 0) check("frame_gap", nbits, 0);
        nbits = 0;
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] d);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      exp_q.push_back(model(d));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n        = 0;
    in_valid = 1'b0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 30000) begin
      n++;
      @(negedge clk);
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ser_out", ser_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(8'h03); wait_idle(); check("cw_03", last_cw, 10'd12);
    send(8'h07); wait_idle(); check("cw_07", last_cw, 10'd30);
    send(8'h80); wait_idle(); check("cw_80", last_cw, 10'd513);
    send(8'hFF); wait_idle(); check("cw_ff", last_cw, 10'h3FC);
    send(8'h00); wait_idle(); check("cw_00", last_cw, 10'd0);
    check("run_00", last_run, 10);

    send(8'h07); send(8'h80); wait_idle();
    check("b2b_run", last_run, 20);
    check("b2b_last_cw", last_cw, 10'd513);

    // Abort a frame while payload bit 4 is on the line.
    send(8'hA5);
    idle(4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_in_rst", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("abort_valid", ser_valid, 0);
    check("abort_last", ser_last, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h05); wait_idle(); check("cw_05", last_cw, 10'd21);

    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1);
  end

endmodule
